// File: rtl/fetch_unit.sv
// Instruction fetch: PC, req/ack memory reads, prefetch FIFO to the decoder.
// Ack in cycle N gives instr_valid in N+1; requests stall while the FIFO is full.
module fetch_unit #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic [15:0]     buf_dat [BUF_DEPTH];
  logic [PC_W-1:0] buf_pc  [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [PC_W-1:0]  redirect_tgt;
  logic [PC_W-1:0]  fetch_pc_adv;
  logic             ack, push, pop, has_room;
  logic [CNT_W-1:0] count_nxt;

  assign redirect_tgt = redirect_pc & ~PC_W'(1);
  assign ack          = mem_req && mem_ack;
  assign pop          = instr_valid && instr_ready;
  // Data returned in the redirect cycle belongs to the abandoned path.
  assign push         = ack && (state == FETCH) && !redirect;
  assign fetch_pc_adv = push ? fetch_pc + PC_W'(2) : fetch_pc;
  assign count_nxt    = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign has_room     = count_nxt < CNT_W'(BUF_DEPTH);

  assign instr_valid = (count != '0);
  assign instr       = buf_dat[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_dat[i] <= '0;
        buf_pc[i]  <= '0;
      end
    end else begin
      count <= count_nxt;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          buf_dat[wr_ptr] <= mem_rdata;
          buf_pc[wr_ptr]  <= fetch_pc;
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        FETCH: begin
          if (redirect && mem_req && !mem_ack) begin
            // Outstanding read must complete on its old address; fetch_pc keeps the target.
            state    <= SQUASH;
            fetch_pc <= redirect_tgt;
          end else if (redirect) begin
            fetch_pc <= redirect_tgt;
            mem_req  <= 1'b1;
            mem_addr <= redirect_tgt;
          end else begin
            fetch_pc <= fetch_pc_adv;
            mem_addr <= fetch_pc_adv;
            mem_req  <= has_room;
            if (!has_room) state <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            state    <= FETCH;
            fetch_pc <= redirect_tgt;
            mem_req  <= 1'b1;
            mem_addr <= redirect_tgt;
          end else if (has_room) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        SQUASH: begin
          if (redirect) fetch_pc <= redirect_tgt;
          if (mem_ack) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= redirect ? redirect_tgt : fetch_pc;
          end
        end
        default: begin
          state   <= FETCH;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory: acks after 'lat' extra cycles of a held request; word = 16'hAD01 + address.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hAD01 + mem_addr;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input logic [15:0] a, input int budget);
    int  n;
    logic found;
    n = 0;
    found = 1'b0;
    while (n < budget && !found) begin
      if (mem_req && mem_addr == a) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk($sformatf("wait_req_%h", a), {31'd0, found}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    lat         = 0;
    step();
    step();

    // Reset state
    chk("rst_valid", instr_valid, 0);
    chk("rst_req",   mem_req,     0);
    chk("rst_addr",  mem_addr,    0);
    chk("rst_instr", instr,       0);
    chk("rst_pc",    instr_pc,    0);

    // 1: zero-wait memory, ready high
    rst_n = 1'b1;
    step();
    chk("t1_req",  mem_req,  1);
    chk("t1_addr", mem_addr, 16'h0000);
    step();
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr,       16'hAD01);
    chk("t1_pc",    instr_pc,    16'h0000);
    chk("t1_addr2", mem_addr,    16'h0002);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t1_stream_pc%0d", k),    instr_pc,    2 * k);
      chk($sformatf("t1_stream_instr%0d", k), instr,       16'hAD01 + 16'(2 * k));
      chk($sformatf("t1_stream_vld%0d", k),   instr_valid, 1);
    end

    // 2: decoder stalled from start
    rst_n = 1'b0;
    instr_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("t2_req_off", mem_req,     0);
    chk("t2_addr4",   mem_addr,    16'h0004);
    chk("t2_instr",   instr,       16'hAD01);
    chk("t2_pc",      instr_pc,    16'h0000);
    chk("t2_valid",   instr_valid, 1);
    step();
    step();
    chk("t2_stable_instr", instr,   16'hAD01);
    chk("t2_stable_req",   mem_req, 0);
    instr_ready = 1'b1;
    step();
    chk("t2_resume_req",  mem_req,  1);
    chk("t2_resume_addr", mem_addr, 16'h0004);
    chk("t2_next_pc",     instr_pc, 16'h0002);
    step();
    chk("t2_pc4",    instr_pc, 16'h0004);
    chk("t2_instr4", instr,    16'hAD05);
    chk("t2_addr6",  mem_addr, 16'h0006);

    // 3: 3-cycle memory, redirect one cycle into the request at 0x0004
    rst_n = 1'b0;
    lat = 2;
    #2;
    rst_n = 1'b1;
    wait_req(16'h0004, 30);
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    chk("t3_hold_req",  mem_req,     1);
    chk("t3_hold_addr", mem_addr,    16'h0004);
    chk("t3_flushed",   instr_valid, 0);
    step();
    chk("t3_new_addr", mem_addr,    16'h0100);
    chk("t3_vld0",     instr_valid, 0);
    step();
    chk("t3_vld1", instr_valid, 0);
    step();
    chk("t3_vld2", instr_valid, 0);
    step();
    chk("t3_valid", instr_valid, 1);
    chk("t3_pc",    instr_pc,    16'h0100);
    chk("t3_instr", instr,       16'hAE01);

    // 4: redirect in the ack cycle
    wait_req(16'h0104, 30);
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("t4_addr",  mem_addr,    16'h0040);
    chk("t4_req",   mem_req,     1);
    chk("t4_vld0",  instr_valid, 0);
    step();
    chk("t4_vld1", instr_valid, 0);
    step();
    chk("t4_vld2", instr_valid, 0);
    step();
    chk("t4_valid", instr_valid, 1);
    chk("t4_pc",    instr_pc,    16'h0040);
    chk("t4_instr", instr,       16'hAD41);

    // 5: reset while a read is outstanding and words are buffered
    instr_ready = 1'b0;
    lat = 0;
    step();
    step();
    step();
    chk("t5_full_req",   mem_req,     0);
    chk("t5_full_valid", instr_valid, 1);
    lat = 9;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t5_pending_req", mem_req,     1);
    chk("t5_buffered",    instr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", instr_valid, 0);
    chk("t5_rst_req",   mem_req,     0);
    chk("t5_rst_addr",  mem_addr,    16'h0000);
    chk("t5_rst_instr", instr,       16'h0000);
    lat = 0;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("t5_restart_addr", mem_addr, 16'h0000);
    chk("t5_restart_req",  mem_req,  1);
    step();
    chk("t5_restart_pc",    instr_pc, 16'h0000);
    chk("t5_restart_instr", instr,    16'hAD01);

    // 6: odd redirect target, then fetch across the top of the address space
    redirect    = 1'b1;
    redirect_pc = 16'h0201;
    step();
    redirect = 1'b0;
    chk("t6_addr200", mem_addr,    16'h0200);
    chk("t6_flush",   instr_valid, 0);
    step();
    chk("t6_pc200",    instr_pc, 16'h0200);
    chk("t6_instr200", instr,    16'hAF01);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("t6_addr_fffe", mem_addr, 16'hFFFE);
    step();
    chk("t6_addr_wrap",  mem_addr, 16'h0000);
    chk("t6_pc_fffe",    instr_pc, 16'hFFFE);
    chk("t6_instr_fffe", instr,    16'hACFF);
    step();
    chk("t6_pc_wrap",    instr_pc, 16'h0000);
    chk("t6_instr_wrap", instr,    16'hAD01);
    chk("t6_addr2",      mem_addr, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
